// File: rtl/tpu_pkg.sv
// tpu_pkg: shared states, control-word field positions and phase lengths for the job sequencer
package tpu_pkg;
  typedef logic [2:0] state_t;
  localparam state_t S_IDLE    = 3'd0;
  localparam state_t S_LOAD_W  = 3'd1;
  localparam state_t S_STREAM  = 3'd2;
  localparam state_t S_DRAIN   = 3'd3;
  localparam state_t S_WRITE   = 3'd4;
  localparam state_t S_NEXT    = 3'd5;
  localparam state_t S_DONE    = 3'd6;
  localparam state_t S_ACKWAIT = 3'd7;
  localparam int CW_CLEAR  = 0;
  localparam int CW_RUN    = 1;
  localparam int CW_ACK    = 2;
  localparam int CW_TILES  = 4;
  localparam int CW_BASE_A = 8;
  localparam int CW_BASE_R = 16;
  function automatic int row_phase_len(input int n);
    return n;
  endfunction
  function automatic int drain_phase_len(input int n);
    return 2 * n - 1;
  endfunction
endpackage

// File: rtl/tpu_job_sequencer_phase_counter.sv
// phase_counter: loadable down-counter whose terminal count marks the last cycle of a timed phase
module phase_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         tc
);
  logic [W-1:0] cnt_q;
  // load on phase entry, then count down and rest at zero
  always_ff @(posedge clk)
    if (rst) cnt_q <= '0;
    else if (load) cnt_q <= load_val;
    else if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
  assign tc = cnt_q == '0;
endmodule

// File: rtl/tpu_job_sequencer.sv
// tpu_job_sequencer: latches an HPS job word and steps the systolic array through each tile
module tpu_job_sequencer
  import tpu_pkg::*;
#(
  parameter int Matrix_Size = 8,
  parameter int Data_Width  = 8,
  parameter int ADDR_W      = 16
) (
  input  logic                           CLOCK,
  input  logic                           RESET,
  input  logic [31:0]                    control_to_FPGA,
  output logic                           control_to_HPS,
  output logic                           busy,
  output logic                           rd_en,
  output logic [ADDR_W-1:0]              rd_addr,
  output logic                           w_load,
  output logic                           a_valid,
  output logic                           acc_clr,
  output logic                           wr_en,
  output logic [ADDR_W-1:0]              wr_addr,
  output logic [$clog2(Matrix_Size)-1:0] row_idx
);
  localparam int N = Matrix_Size;
  localparam int RW = $clog2(N);
  localparam int CW = $clog2(2 * N);
  localparam int dw_unused = Data_Width;
  localparam logic [CW-1:0] LEN_ROW = CW'(row_phase_len(N) - 1);
  localparam logic [CW-1:0] LEN_DRAIN = CW'(drain_phase_len(N) - 1);
  state_t state_q, state_d;
  logic [3:0] tile_q, tile_d, t_q, t_d;
  logic [RW-1:0] row_q, row_d;
  logic [7:0] a_q, a_d;
  logic [15:0] r_q, r_d;
  logic [CW-1:0] load_val;
  logic load, tc, clear, run, ack, unused_rsvd;
  logic [ADDR_W-1:0] rd_sum, wr_sum;
  assign clear = control_to_FPGA[CW_CLEAR];
  assign run = control_to_FPGA[CW_RUN];
  assign ack = control_to_FPGA[CW_ACK];
  assign unused_rsvd = control_to_FPGA[3];
  phase_counter #(.W(CW)) u_phase (
    .clk(CLOCK), .rst(RESET), .load(load), .load_val(load_val), .tc(tc)
  );
  // next-state: phase sequencing, job latch, and clear override
  always_comb begin
    state_d = state_q;
    tile_d = tile_q;
    row_d = row_q;
    t_d = t_q;
    a_d = a_q;
    r_d = r_q;
    load = 1'b0;
    load_val = LEN_ROW;
    case (state_q)
      S_IDLE, S_ACKWAIT:
        if (run && (state_q == S_IDLE || !ack)) begin
          t_d = control_to_FPGA[CW_TILES +: 4];
          a_d = control_to_FPGA[CW_BASE_A +: 8];
          r_d = control_to_FPGA[CW_BASE_R +: 16];
          tile_d = '0;
          row_d = '0;
          load = 1'b1;
          state_d = (t_d == '0) ? S_DONE : S_LOAD_W;
        end else if (state_q == S_ACKWAIT && !ack) state_d = S_IDLE;
      S_LOAD_W:
        if (tc) begin
          state_d = S_STREAM;
          row_d = '0;
          load = 1'b1;
        end else row_d = row_q + 1'b1;
      S_STREAM:
        if (tc) begin
          state_d = S_DRAIN;
          row_d = '0;
          load = 1'b1;
          load_val = LEN_DRAIN;
        end else row_d = row_q + 1'b1;
      S_DRAIN:
        if (tc) begin
          state_d = S_WRITE;
          load = 1'b1;
        end
      S_WRITE:
        if (tc) begin
          state_d = S_NEXT;
          row_d = '0;
        end else row_d = row_q + 1'b1;
      S_NEXT:
        if (tile_q + 4'd1 == t_q) state_d = S_DONE;
        else begin
          tile_d = tile_q + 4'd1;
          state_d = S_LOAD_W;
          load = 1'b1;
        end
      S_DONE: if (ack) state_d = S_ACKWAIT;
      default: state_d = S_IDLE;
    endcase
    if (clear) begin
      state_d = S_IDLE;
      tile_d = '0;
      row_d = '0;
    end
  end
  assign rd_sum = ADDR_W'(a_d) + (ADDR_W'(tile_d) << (RW + 1))
                + (state_d == S_STREAM ? ADDR_W'(N) : '0) + ADDR_W'(row_d);
  assign wr_sum = ADDR_W'(r_d) + (ADDR_W'(tile_d) << RW) + ADDR_W'(row_d);
  // state, counters and latched job fields
  always_ff @(posedge CLOCK)
    if (RESET) begin
      state_q <= S_IDLE;
      tile_q <= '0;
      row_q <= '0;
      t_q <= '0;
      a_q <= '0;
      r_q <= '0;
    end else begin
      state_q <= state_d;
      tile_q <= tile_d;
      row_q <= row_d;
      t_q <= t_d;
      a_q <= a_d;
      r_q <= r_d;
    end
  // outputs registered from the state being entered so they align with it
  always_ff @(posedge CLOCK)
    if (RESET) begin
      control_to_HPS <= 1'b0;
      busy <= 1'b0;
      rd_en <= 1'b0;
      rd_addr <= '0;
      w_load <= 1'b0;
      a_valid <= 1'b0;
      acc_clr <= 1'b0;
      wr_en <= 1'b0;
      wr_addr <= '0;
      row_idx <= '0;
    end else begin
      control_to_HPS <= state_d == S_DONE;
      busy <= !(state_d == S_IDLE || state_d == S_DONE || state_d == S_ACKWAIT);
      rd_en <= state_d == S_LOAD_W || state_d == S_STREAM;
      rd_addr <= (state_d == S_LOAD_W || state_d == S_STREAM) ? rd_sum : '0;
      w_load <= state_d == S_LOAD_W;
      a_valid <= state_d == S_STREAM;
      acc_clr <= state_d == S_LOAD_W && state_q != S_LOAD_W;
      wr_en <= state_d == S_WRITE;
      wr_addr <= state_d == S_WRITE ? wr_sum : '0;
      row_idx <= row_d;
    end
endmodule

// File: tb/tb_tpu_job_sequencer.sv
// tb_tpu_job_sequencer: scoreboard bench driving a 16-bit and an 8-bit address instance in lockstep
module tb_tpu_job_sequencer;
  logic clk = 1'b0, rst = 1'b1;
  logic [31:0] cw = '0;
  always #5 clk = ~clk;
  logic done_a, busy_a, rd_en_a, w_load_a, a_valid_a, acc_clr_a, wr_en_a;
  logic [15:0] rd_addr_a, wr_addr_a;
  logic [2:0] row_a;
  logic done_b, busy_b, rd_en_b, w_load_b, a_valid_b, acc_clr_b, wr_en_b;
  logic [7:0] rd_addr_b, wr_addr_b;
  logic [2:0] row_b;
  tpu_job_sequencer #(.Matrix_Size(8), .Data_Width(8), .ADDR_W(16)) dut_a (
    .CLOCK(clk), .RESET(rst), .control_to_FPGA(cw), .control_to_HPS(done_a), .busy(busy_a),
    .rd_en(rd_en_a), .rd_addr(rd_addr_a), .w_load(w_load_a), .a_valid(a_valid_a),
    .acc_clr(acc_clr_a), .wr_en(wr_en_a), .wr_addr(wr_addr_a), .row_idx(row_a));
  tpu_job_sequencer #(.Matrix_Size(8), .Data_Width(8), .ADDR_W(8)) dut_b (
    .CLOCK(clk), .RESET(rst), .control_to_FPGA(cw), .control_to_HPS(done_b), .busy(busy_b),
    .rd_en(rd_en_b), .rd_addr(rd_addr_b), .w_load(w_load_b), .a_valid(a_valid_b),
    .acc_clr(acc_clr_b), .wr_en(wr_en_b), .wr_addr(wr_addr_b), .row_idx(row_b));
  int total = 0, bad = 0;
  logic [19:0] rq_a[$], rq_b[$], wq_a[$], wq_b[$];
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic push_job(input logic [31:0] w);
    int tn = int'(w[7:4]);
    int a = int'(w[15:8]);
    int r = int'(w[31:16]);
    logic [19:0] x;
    for (int t = 0; t < tn; t++) begin
      for (int k = 0; k < 8; k++) begin
        x = {3'(k), 1'b0, 16'(a + t * 16 + k)};
        rq_a.push_back(x);
        rq_b.push_back(x);
      end
      for (int k = 0; k < 8; k++) begin
        x = {3'(k), 1'b1, 16'(a + t * 16 + 8 + k)};
        rq_a.push_back(x);
        rq_b.push_back(x);
      end
      for (int k = 0; k < 8; k++) begin
        x = {3'(k), 1'b0, 16'(r + t * 8 + k)};
        wq_a.push_back(x);
        wq_b.push_back(x);
      end
    end
  endtask
  task automatic flush();
    rq_a.delete();
    rq_b.delete();
    wq_a.delete();
    wq_b.delete();
  endtask
  task automatic chk_empty(input string name);
    chk({name, "_queues"}, {8'(rq_a.size()), 8'(rq_b.size()), 8'(wq_a.size()), 8'(wq_b.size())}, 0);
  endtask
  task automatic chk_zero(input string name);
    chk({name, "_a"}, {done_a, busy_a, rd_en_a, w_load_a, a_valid_a, acc_clr_a, wr_en_a,
                       rd_addr_a, wr_addr_a, row_a}, 0);
    chk({name, "_b"}, {done_b, busy_b, rd_en_b, w_load_b, a_valid_b, acc_clr_b, wr_en_b,
                       rd_addr_b, wr_addr_b, row_b}, 0);
  endtask
  task automatic wait_done(input string name, input int expn);
    int n = 0;
    while (done_a !== 1'b1 && n < 2000) begin
      step(1);
      n++;
    end
    chk({name, "_cycles"}, n, expn);
    chk({name, "_done_b"}, done_b, 1);
  endtask
  task automatic ack_idle(input string name);
    cw = 32'h0000_0004;
    step(1);
    chk({name, "_done_fall"}, {done_a, done_b}, 0);
    cw = 32'h0;
    step(2);
    chk({name, "_idle"}, {busy_a, busy_b, done_a, done_b}, 0);
  endtask
  always @(negedge clk) begin : mon
    logic [19:0] e;
    if (!rst) begin
      if (rd_en_a) begin
        if (rq_a.size() == 0) begin
          total++;
          bad++;
          $display("FAIL rd_unexpected_a got addr=%0h want no read", rd_addr_a);
        end else begin
          e = rq_a.pop_front();
          chk("rd_addr_a", rd_addr_a, e[15:0]);
          chk("rd_kind_a", {a_valid_a, w_load_a}, {e[16], ~e[16]});
          chk("rd_row_a", row_a, e[19:17]);
        end
      end
      if (rd_en_b) begin
        if (rq_b.size() == 0) begin
          total++;
          bad++;
          $display("FAIL rd_unexpected_b got addr=%0h want no read", rd_addr_b);
        end else begin
          e = rq_b.pop_front();
          chk("rd_addr_b", rd_addr_b, e[7:0]);
          chk("rd_kind_b", {a_valid_b, w_load_b}, {e[16], ~e[16]});
          chk("rd_row_b", row_b, e[19:17]);
        end
      end
      if (wr_en_a) begin
        if (wq_a.size() == 0) begin
          total++;
          bad++;
          $display("FAIL wr_unexpected_a got addr=%0h want no write", wr_addr_a);
        end else begin
          e = wq_a.pop_front();
          chk("wr_addr_a", wr_addr_a, e[15:0]);
          chk("wr_row_a", row_a, e[19:17]);
        end
      end
      if (wr_en_b) begin
        if (wq_b.size() == 0) begin
          total++;
          bad++;
          $display("FAIL wr_unexpected_b got addr=%0h want no write", wr_addr_b);
        end else begin
          e = wq_b.pop_front();
          chk("wr_addr_b", wr_addr_b, e[7:0]);
          chk("wr_row_b", row_b, e[19:17]);
        end
      end
    end
  end
  initial begin
    #400000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1);
  end
  initial begin
    step(3);
    chk_zero("reset");
    rst = 1'b0;
    step(1);
    chk_zero("idle_after_reset");
    push_job(32'h0800_40A2);
    cw = 32'h0800_40A2;
    step(1);
    chk("job1_first_rd", {rd_en_a, acc_clr_a, busy_a, rd_addr_a}, {3'b111, 16'h0040});
    step(19);
    cw = 32'h1234_0030;
    wait_done("job1", 381);
    chk_empty("job1");
    step(3);
    chk("done_hold", {done_a, done_b}, 2'b11);
    cw = 32'h0800_40A6;
    step(1);
    chk("done_fall_after_ack", {done_a, done_b}, 0);
    push_job(32'h0800_40A2);
    cw = 32'h0800_40A2;
    step(1);
    chk("job2_restart", {rd_en_a, acc_clr_a, rd_addr_a}, {2'b11, 16'h0040});
    wait_done("job2", 400);
    chk_empty("job2");
    ack_idle("job2");
    push_job(32'h0800_40A2);
    cw = 32'h0800_40A2;
    step(11);
    chk("in_stream", {a_valid_a, a_valid_b}, 2'b11);
    cw = 32'h0000_0001;
    step(1);
    chk_zero("after_clear");
    flush();
    push_job(32'h0800_4012);
    cw = 32'h0800_4012;
    step(1);
    chk("clear_restart", {rd_en_a, rd_addr_a, rd_addr_b}, {1'b1, 16'h0040, 8'h40});
    wait_done("restart", 40);
    chk_empty("restart");
    ack_idle("restart");
    cw = 32'h0000_4002;
    step(1);
    chk("t0_done", {done_a, done_b, busy_a, busy_b}, 4'b1100);
    ack_idle("t0");
    chk_empty("t0");
    push_job(32'h1234_FFF2);
    cw = 32'h1234_FFF2;
    step(1);
    chk("wrap_first", {rd_addr_a, rd_addr_b}, {16'h00FF, 8'hFF});
    step(1);
    chk("wrap_second", {rd_addr_a, rd_addr_b}, {16'h0100, 8'h00});
    wait_done("wrap", 599);
    chk_empty("wrap");
    ack_idle("wrap");
    push_job(32'h0800_40A2);
    cw = 32'h0800_40A2;
    step(6);
    rst = 1'b1;
    cw = 32'h0800_40A3;
    step(1);
    chk_zero("reset_clear_run");
    flush();
    rst = 1'b0;
    step(2);
    chk_zero("clear_over_run");
    cw = 32'h0;
    step(2);
    chk_empty("final");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/tpu_job_sequencer.md
# tpu_job_sequencer

Control-word decoder and job sequencer between the HPS control register and the systolic-array datapath. It latches a job from `control_to_FPGA`, then steps the array through weight load, input streaming, drain and result write-back for each tile. It reports completion to the HPS on `control_to_HPS` with a done/ack handshake, and sits directly under `FinalDesign`, next to the array and the on-chip buffers.

## Interface
- `Matrix_Size`, 8: array dimension N (N×N PEs); power of two, ≥2
- `Data_Width`, 8: operand width; not used in logic, kept for width checks
- `ADDR_W`, 16: buffer address width
- `CLOCK`  in  1  single clock; all logic on rising edge
- `RESET`  in  1  synchronous, active-high reset
- `control_to_FPGA`  in  32  HPS command word:
  - [0] clear
  - [1] run
  - [2] ack
  - [3] reserved
  - [7:4] tile count T
  - [15:8] operand base A
  - [31:16] result base R
- `control_to_HPS`  out  1  done flag
- `busy`  out  1  job in progress (any state except IDLE/DONE/ACKWAIT)
- `rd_en`  out  1  operand buffer read strobe
- `rd_addr`  out  ADDR_W  operand buffer address
- `w_load`  out  1  array shifts in a weight row this cycle
- `a_valid`  out  1  array accepts an input row this cycle (skewing is inside the array)
- `acc_clr`  out  1  clear PE accumulators, one cycle
- `wr_en`  out  1  result buffer write strobe
- `wr_addr`  out  ADDR_W  result buffer address
- `row_idx`  out  $clog2(N)  current row within phase

## Operation
- States: IDLE, LOAD_W, STREAM, DRAIN, WRITE, NEXT, DONE, ACKWAIT.
- IDLE:
  - If run=1 and clear=0: latch T, A, R into registers.
  - T≠0: pulse acc_clr and go to LOAD_W with tile=0, row=0.
  - T=0: go to DONE; no buffer or array activity.
- LOAD_W, N cycles: rd_en=1, w_load=1, rd_addr = A + tile·2N + row.
- STREAM, N cycles: rd_en=1, a_valid=1, rd_addr = A + tile·2N + N + row.
- DRAIN, 2N−1 cycles: all strobes 0. row_idx holds 0.
- WRITE, N cycles: wr_en=1, wr_addr = R + tile·N + row.
- NEXT, 1 cycle:
  - If tile+1 = T: go to DONE.
  - Otherwise: tile increments, acc_clr pulses, go to LOAD_W.
- DONE: control_to_HPS=1. When ack=1, go to ACKWAIT.
- ACKWAIT: control_to_HPS=0. When ack=0:
  - run=1: start a new job exactly as from IDLE, relatching the word.
  - run=0: go to IDLE.
- Latched fields: changes to control_to_FPGA fields after latch are ignored until the next start. run dropping mid-job does not abort.
- Clear:
  - clear=1 in any state forces IDLE on the next edge and zeroes tile and row counters.
  - Clear takes priority over run/ack in the same cycle.
  - RESET has the same effect and dominates clear.
- Address arithmetic:
  - A zero-extended to ADDR_W; R is ADDR_W bits.
  - All sums are computed modulo 2^ADDR_W (wrap, no saturation).
  - row_idx = row counter, which wraps to 0 at each phase change.

## Timing
- Reset values: all outputs 0, state IDLE, counters 0.
- All outputs are registered, and change on the edge that enters the state.
- Latency:
  - Run seen in IDLE → first rd_en: 1 cycle (acc_clr is high in that same cycle).
  - Per tile: N + N + (2N−1) + N + 1 = 5N cycles (40 for N=8).
  - Done rises T·5N cycles after the first LOAD_W cycle.
- Operand read data is assumed valid one cycle after rd_en. The array absorbs this; DRAIN length already includes it.
- Handshake: done stays high through any number of cycles until ack=1. It falls on the edge after ack is sampled high. A new job starts only after ack is seen low.
- T=15 is the maximum tile count. The tile counter is 4 bits and never wraps within a job.

## Structure
- Shared package `tpu_pkg` holds:
  - state enum
  - control-word bit/field positions (CW_CLEAR, CW_RUN, CW_ACK, CW_TILES, CW_BASE_A, CW_BASE_R)
  - phase-length constants derived from Matrix_Size
- One sub-module is natural: `phase_counter`. It is a loadable down-counter with a terminal-count flag, shared by all timed states.

## Test plan
- N=8, word 0x080040A2 (T=10, A=0x40, R=0x0800):
  - 10 tiles, done after 400 cycles of activity.
  - First rd_addr=0x0040; tile 1 starts at rd_addr=0x0050.
  - Last wr_addr=0x0800+9·8+7=0x084F.
- Handshake: at done, drive 0x080040A6 for 1 cycle, then 0x080040A2:
  - done falls one cycle after ack.
  - A second identical job runs and done rises again.
- Clear mid-STREAM (word 0x00000001):
  - Next cycle IDLE with all strobes 0.
  - A later run restarts at tile 0, rd_addr=A.
- T=0 (word 0x00004002): done within 2 cycles, rd_en/wr_en never asserted.
- Wrap: A=0xFF, T=15 with ADDR_W=8 override → rd_addr wraps modulo 256 without glitch.
- Field change mid-job (R altered during DRAIN) → wr_addr still uses latched R; RESET asserted with clear and run simultaneously → IDLE, outputs 0.
